result_ram_reader: RTL and testbench
====================================

# result_ram_reader

Read-side drain engine for the NPU result RAM. On a `start` command it walks a contiguous, wrap-around address range of the result RAM and streams each 32-bit word out over a valid/ready interface. The stream feeds the host export/debug path. While `busy` is high, the top level routes the RAM address port to this block. The writer side must be idle during a drain.

## Interface
Parameters:
- `ADDR_W`, 6: result RAM address width (depth = 2**ADDR_W = 64).
- `DATA_W`, 32: RAM word width.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `base_addr` in ADDR_W: first RAM address to read; latched with `start`.
- `count` in ADDR_W+1: number of words, 0..64; latched with `start`.
- `ram_addr` out ADDR_W: read address to the RAM; driven directly from the internal pointer register.
- `ram_dout` in DATA_W: RAM combinational read data for `ram_addr`, same cycle.
- `out_valid` out 1: `out_data` holds a word.
- `out_ready` in 1: consumer accepts the word on this edge if `out_valid` is high.
- `out_data` out DATA_W: streamed word.
- `out_last` out 1: qualifies the final word of the command.
- `busy` out 1: high from the cycle after `start` is accepted until DONE is left.
- `done` out 1: single-cycle completion pulse.

## Operation
- FSM states: IDLE, STREAM, DONE.
- **Registers:** `ptr` (ADDR_W), `fetch_left` (ADDR_W+1), and the output word register (`out_valid`, `out_data`, `out_last`).
- **IDLE:**
  - `start`=1 and `count`!=0: `ptr`<=`base_addr`, `fetch_left`<=`count`, go to STREAM.
  - `start`=1 and `count`==0: go directly to DONE; no words are emitted.
- **STREAM, load condition:** `load` = (`fetch_left`!=0) && (!`out_valid` || `out_ready`).
- **STREAM, on `load`:**
  - `out_data`<=`ram_dout` and `out_valid`<=1.
  - `out_last`<=(`fetch_left`==1).
  - `ptr`<=`ptr`+1, modulo 2**ADDR_W (63 wraps to 0).
  - `fetch_left`<=`fetch_left`-1.
- **STREAM, no `load` but `out_valid`&&`out_ready`:** `out_valid`<=0 and `out_last`<=0.
- **STREAM exit:** handshake on a word with `out_last`=1 -> DONE, with `out_valid`<=0 and `out_last`<=0.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
- `busy` = (state != IDLE).
- `start` is ignored while not in IDLE.
- **Stream rules:**
  - Once `out_valid`=1, `out_data` and `out_last` hold stable until the handshake.
  - `out_valid` never drops without a handshake.
- The block never writes the RAM. Contents are read as they are at fetch time.

## Timing
- Reset values: state=IDLE, `ptr`=0, `fetch_left`=0, `ram_addr`=0, `out_valid`=0, `out_data`=0, `out_last`=0, `busy`=0, `done`=0.
- `start` sampled at edge T: `busy`=1 from T+1. The first word is fetched at edge T+1, so `out_valid`=1 from T+2.
- Throughput: with `out_ready` held high, one word per cycle, with no bubbles across the wrap 63->0.
- N-word command with `out_ready` always 1:
  - Words are valid in cycles T+2 .. T+N+1.
  - `done` is high in cycle T+N+2.
  - `busy` falls in cycle T+N+3.
  - The next `start` is accepted at edge T+N+3.
- `count`=0: `busy`=1 and `done`=1 both in cycle T+1; back in IDLE at T+2.
- Backpressure: with `out_ready`=0, the held word stays unchanged and `ptr` does not advance. Fetch resumes on the same edge that the handshake completes.
- `rst` mid-command: all registers return to reset values at the next edge. No `done` pulse; any partial word is discarded.

## Test plan
- **Basic drain:** preload RAM[0]=DEADBEEF, RAM[1]=12345678; `start` with base=0, count=2, `out_ready`=1. Expect out words DEADBEEF then 12345678 in consecutive cycles, `out_last` on the second, and `done` one cycle after it.
- **Wrap-around:** RAM[62..63]=A0,A1 and RAM[0..1]=A2,A3; base=62, count=4. Expect A0,A1,A2,A3 on consecutive cycles, `ram_addr` sequence 62,63,0,1, and `out_last` on A3.
- **Backpressure:** base=0, count=3, with `out_ready` toggling 1,0,0,1,0,1. Each word is held stable while not ready, no word is lost or duplicated, and exactly 3 handshakes occur.
- **Full and empty counts:** RAM[i]=i; count=64 from base=5 yields 5..63 then 0..4, 64 words, `out_last` on word 4. count=0 yields `done` at T+1, no `out_valid`, and `busy` high for one cycle.
- **Reset and ignored start:** reset asserted after the 2nd word of a 10-word drain; next cycle all outputs are at reset values and no `done` pulse occurs. `start` pulsed during an active drain is ignored and the word count is unchanged.

Source files
------------

// File: rtl/result_ram_reader_if.sv
// Output word stream of the result RAM drain engine (valid/ready, with last marker).
interface result_ram_reader_if #(
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/result_ram_reader.sv
// Result RAM drain engine: walks a wrap-around address range and streams each
// word through a one-entry output register with valid/ready flow control.
module result_ram_reader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  result_ram_reader_if.master os,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   fetch_left;
  logic              load, hs;

  // The RAM is combinational, so the pointer addresses the word fetched this edge.
  assign ram_addr = ptr;

  // A fetch refills the output register whenever it is empty or draining this cycle.
  assign hs   = os.out_valid && os.out_ready;
  assign load = (state == STREAM) && (fetch_left != '0) && (!os.out_valid || os.out_ready);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (start) state_nxt = (count != '0) ? STREAM : DONE;
      STREAM:  if (hs && os.out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer, remaining-count and output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      fetch_left   <= '0;
      os.out_valid <= 1'b0;
      os.out_data  <= '0;
      os.out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start && count != '0) begin
        ptr        <= base_addr;
        fetch_left <= count;
      end
      if (load) begin
        os.out_data  <= ram_dout;
        os.out_valid <= 1'b1;
        os.out_last  <= (fetch_left == (ADDR_W+1)'(1));
        ptr          <= ptr + ADDR_W'(1);   // natural wrap 63 -> 0
        fetch_left   <= fetch_left - (ADDR_W+1)'(1);
      end else if (hs) begin
        // Includes the final word: fetch_left is already zero by then.
        os.out_valid <= 1'b0;
        os.out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_ram_reader.sv
// Directed bench for result_ram_reader: per-cycle vector tables plus
// hand-written sequences for full-range, ignored-start and reset cases.
module tb_result_ram_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  base_addr;
  logic [6:0]  count;
  logic [5:0]  ram_addr;
  logic [31:0] ram_dout;
  logic        busy, done;
  logic [31:0] mem [64];

  result_ram_reader_if #(.DATA_W(32)) sif ();

  result_ram_reader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .os(sif.master),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign ram_dout = mem[ram_addr];

  // Bookkeeping of accepted words and done pulses, sampled on the active edge.
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] words [$];
  always @(posedge clk) begin
    if (!rst && sif.out_valid && sif.out_ready) begin
      hs_cnt++;
      words.push_back(sif.out_data);
    end
    if (!rst && done) done_cnt++;
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        st;
    logic [5:0]  base;
    logic [6:0]  cnt;
    logic        rdy;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_last;
    logic        e_busy;
    logic        e_done;
    logic [5:0]  e_addr;
  } vec_t;

  vec_t tv [$];

  function automatic void add(logic st, logic [5:0] b, logic [6:0] c, logic r,
                              logic v, logic [31:0] d, logic l, logic bz, logic dn,
                              logic [5:0] a);
    vec_t x;
    x.st = st; x.base = b; x.cnt = c; x.rdy = r;
    x.e_valid = v; x.e_data = d; x.e_last = l; x.e_busy = bz; x.e_done = dn; x.e_addr = a;
    tv.push_back(x);
  endfunction

  // Each vector drives inputs for one cycle, then checks outputs after the edge.
  task automatic run_range(input int lo, input int hi, input string tag);
    for (int i = lo; i < hi; i++) begin
      start = tv[i].st; base_addr = tv[i].base; count = tv[i].cnt; sif.out_ready = tv[i].rdy;
      step();
      chk($sformatf("%s[%0d].valid", tag, i - lo), 32'(sif.out_valid), 32'(tv[i].e_valid));
      chk($sformatf("%s[%0d].last",  tag, i - lo), 32'(sif.out_last),  32'(tv[i].e_last));
      chk($sformatf("%s[%0d].busy",  tag, i - lo), 32'(busy),          32'(tv[i].e_busy));
      chk($sformatf("%s[%0d].done",  tag, i - lo), 32'(done),          32'(tv[i].e_done));
      chk($sformatf("%s[%0d].addr",  tag, i - lo), 32'(ram_addr),      32'(tv[i].e_addr));
      if (tv[i].e_valid)
        chk($sformatf("%s[%0d].data", tag, i - lo), sif.out_data, tv[i].e_data);
    end
  endtask

  initial begin
    int s1, s2, s3, s4, s5, hs0, w0, dn0;

    // Basic drain: base 0, count 2
    add(1, 0, 2, 1,  0, 32'h0,          0, 1, 0, 0);
    add(0, 0, 0, 1,  1, 32'hDEADBEEF,   0, 1, 0, 1);
    add(0, 0, 0, 1,  1, 32'h12345678,   1, 1, 0, 2);
    add(0, 0, 0, 1,  0, 32'h0,          0, 1, 1, 2);
    add(0, 0, 0, 1,  0, 32'h0,          0, 0, 0, 2);
    s1 = tv.size();
    // Wrap-around: base 62, count 4
    add(1, 62, 4, 1, 0, 32'h0,  0, 1, 0, 62);
    add(0, 0, 0, 1,  1, 32'hA0, 0, 1, 0, 63);
    add(0, 0, 0, 1,  1, 32'hA1, 0, 1, 0, 0);
    add(0, 0, 0, 1,  1, 32'hA2, 0, 1, 0, 1);
    add(0, 0, 0, 1,  1, 32'hA3, 1, 1, 0, 2);
    add(0, 0, 0, 1,  0, 32'h0,  0, 1, 1, 2);
    add(0, 0, 0, 1,  0, 32'h0,  0, 0, 0, 2);
    s2 = tv.size();
    // Backpressure: base 0, count 3, ready 1,0,0,1,0,1 after start
    add(1, 0, 3, 1,  0, 32'h0,  0, 1, 0, 0);
    add(0, 0, 0, 1,  1, 32'h11, 0, 1, 0, 1);
    add(0, 0, 0, 0,  1, 32'h11, 0, 1, 0, 1);
    add(0, 0, 0, 0,  1, 32'h11, 0, 1, 0, 1);
    add(0, 0, 0, 1,  1, 32'h22, 0, 1, 0, 2);
    add(0, 0, 0, 0,  1, 32'h22, 0, 1, 0, 2);
    add(0, 0, 0, 1,  1, 32'h33, 1, 1, 0, 3);
    add(0, 0, 0, 1,  0, 32'h0,  0, 1, 1, 3);
    add(0, 0, 0, 1,  0, 32'h0,  0, 0, 0, 3);
    s3 = tv.size();
    // Empty command: count 0, pointer untouched
    add(1, 20, 0, 1, 0, 32'h0, 0, 1, 1, 3);
    add(0, 0, 0, 1,  0, 32'h0, 0, 0, 0, 3);
    add(0, 0, 0, 1,  0, 32'h0, 0, 0, 0, 3);
    s4 = tv.size();

    // Reset state
    rst = 1'b1; start = 1'b0; base_addr = '0; count = '0; sif.out_ready = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    step(); step();
    chk("rst.valid", 32'(sif.out_valid), 32'd0);
    chk("rst.data",  sif.out_data,       32'd0);
    chk("rst.last",  32'(sif.out_last),  32'd0);
    chk("rst.busy",  32'(busy),          32'd0);
    chk("rst.done",  32'(done),          32'd0);
    chk("rst.addr",  32'(ram_addr),      32'd0);
    rst = 1'b0;
    step();

    mem[0] = 32'hDEADBEEF; mem[1] = 32'h12345678;
    run_range(0, s1, "basic");
    mem[62] = 32'hA0; mem[63] = 32'hA1; mem[0] = 32'hA2; mem[1] = 32'hA3;
    run_range(s1, s2, "wrap");
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
    hs0 = hs_cnt; w0 = words.size();
    run_range(s2, s3, "bp");
    chk("bp.handshakes", 32'(hs_cnt - hs0), 32'd3);
    if (words.size() >= w0 + 3) begin
      chk("bp.word0", words[w0],     32'h11);
      chk("bp.word1", words[w0 + 1], 32'h22);
      chk("bp.word2", words[w0 + 2], 32'h33);
    end
    run_range(s3, s4, "empty");

    // Full range: base 5, count 64
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    sif.out_ready = 1'b1;
    start = 1'b1; base_addr = 6'd5; count = 7'd64;
    step();
    start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      step();
      chk($sformatf("full[%0d].valid", k), 32'(sif.out_valid), 32'd1);
      chk($sformatf("full[%0d].data", k),  sif.out_data,       32'((5 + k) % 64));
      chk($sformatf("full[%0d].last", k),  32'(sif.out_last),  32'(k == 63));
    end
    step();
    chk("full.done", 32'(done), 32'd1);
    step();
    chk("full.busy", 32'(busy), 32'd0);

    // Start pulsed mid-drain must be ignored: base 10, count 10
    hs0 = hs_cnt;
    start = 1'b1; base_addr = 6'd10; count = 7'd10;
    step();
    for (int k = 0; k < 10; k++) begin
      start = (k == 3); base_addr = 6'd40; count = 7'd2;
      step();
      chk($sformatf("ign[%0d].data", k), sif.out_data,      32'(10 + k));
      chk($sformatf("ign[%0d].last", k), 32'(sif.out_last), 32'(k == 9));
    end
    start = 1'b0;
    step();
    chk("ign.done", 32'(done), 32'd1);
    step();
    chk("ign.handshakes", 32'(hs_cnt - hs0), 32'd10);
    chk("ign.busy", 32'(busy), 32'd0);

    // Reset after the second word of a 10-word drain
    start = 1'b1; base_addr = 6'd20; count = 7'd10;
    step();
    start = 1'b0;
    step(); step();
    chk("mid.word2", sif.out_data, 32'd21);
    dn0 = done_cnt;
    rst = 1'b1;
    step();
    chk("mid.valid", 32'(sif.out_valid), 32'd0);
    chk("mid.data",  sif.out_data,       32'd0);
    chk("mid.last",  32'(sif.out_last),  32'd0);
    chk("mid.busy",  32'(busy),          32'd0);
    chk("mid.done",  32'(done),          32'd0);
    chk("mid.addr",  32'(ram_addr),      32'd0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mid.nodone", 32'(done_cnt - dn0), 32'd0);
    chk("mid.idle",   32'(busy),           32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
